// File: rtl/usb_burst_reader.sv
// Drains 10-bit samples from a read-ahead FIFO and emits fixed-length bursts of
// 16-bit words to the FX3 GPIF write bus, with underrun counting and a test pattern.
module usb_burst_reader #(
    parameter int BURST_WORDS = 4096,
    parameter int COUNT_WIDTH = 13,
    parameter int GAP_CYCLES  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        testMode,
    input  logic [9:0]  fifoData,
    input  logic        fifoEmpty,
    input  logic        fifoHalfFull,
    output logic        fifoAck,
    input  logic        usbReady,
    output logic [15:0] usbData,
    output logic        usbWrite,
    output logic        usbEndOfBurst,
    output logic        busy,
    output logic [15:0] underrunCount,
    output logic [1:0]  debugState
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int GAP_WIDTH = $clog2(GAP_CYCLES + 2);
    localparam logic [COUNT_WIDTH-1:0] LAST_WORD = COUNT_WIDTH'(BURST_WORDS - 1);
    localparam logic [GAP_WIDTH-1:0]   GAP_LAST  = GAP_WIDTH'(GAP_CYCLES);

    state_t                 state;
    state_t                 state_next;
    logic [COUNT_WIDTH-1:0] word_cnt;
    logic [GAP_WIDTH-1:0]   gap_cnt;
    logic [9:0]             test_cnt;
    logic                   last_word;
    logic                   underrun;

    assign debugState = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake: a word moves out of the FIFO on any cycle where fifoAck=1, i.e. BURST
    // with !fifoEmpty (FIFO valid) and usbReady (FX3 ready); it appears on usbWrite one cycle later.
    always_comb begin
        state_next = state;
        fifoAck    = 1'b0;
        busy       = 1'b0;
        underrun   = 1'b0;
        last_word  = 1'b0;
        case (state)
            IDLE: begin
                if (enable && fifoHalfFull && usbReady) begin
                    state_next = BURST;
                end
            end
            BURST: begin
                busy      = 1'b1;
                fifoAck   = !fifoEmpty && usbReady;
                underrun  = fifoEmpty && usbReady;
                last_word = fifoAck && (word_cnt == LAST_WORD);
                if (last_word) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                busy = 1'b1;
                // First GAP cycle carries the final word; GAP_CYCLES idle cycles follow it.
                if (gap_cnt == GAP_LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            fifoAck   = 1'b0;
            underrun  = 1'b0;
            last_word = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            usbData       <= 16'd0;
            usbWrite      <= 1'b0;
            usbEndOfBurst <= 1'b0;
            underrunCount <= 16'd0;
            word_cnt      <= '0;
            gap_cnt       <= '0;
            test_cnt      <= 10'd0;
        end else begin
            usbWrite      <= fifoAck;
            usbEndOfBurst <= last_word;
            if (fifoAck) begin
                usbData  <= {6'd0, (testMode ? test_cnt : fifoData)};
                word_cnt <= word_cnt + COUNT_WIDTH'(1);
                if (testMode) begin
                    test_cnt <= test_cnt + 10'd1;
                end
            end
            if (state == IDLE) begin
                word_cnt <= '0;
            end
            if (state == GAP) begin
                gap_cnt <= gap_cnt + GAP_WIDTH'(1);
            end else begin
                gap_cnt <= '0;
            end
            if (underrun && (underrunCount != 16'hFFFF)) begin
                underrunCount <= underrunCount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_usb_burst_reader.sv
// Bench for usb_burst_reader: emulated read-ahead FIFO, directed burst scenarios,
// then randomized traffic, all compared against a word-level behavioural model.
module tb_usb_burst_reader;

    localparam int BW  = 16;
    localparam int GAP = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        testMode;
    logic [9:0]  fifoData;
    logic        fifoEmpty;
    logic        fifoHalfFull;
    logic        fifoAck;
    logic        usbReady;
    logic [15:0] usbData;
    logic        usbWrite;
    logic        usbEndOfBurst;
    logic        busy;
    logic [15:0] underrunCount;
    logic [1:0]  debugState;

    always #5 clock = ~clock;

    usb_burst_reader #(
        .BURST_WORDS(BW),
        .GAP_CYCLES (GAP)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .testMode     (testMode),
        .fifoData     (fifoData),
        .fifoEmpty    (fifoEmpty),
        .fifoHalfFull (fifoHalfFull),
        .fifoAck      (fifoAck),
        .usbReady     (usbReady),
        .usbData      (usbData),
        .usbWrite     (usbWrite),
        .usbEndOfBurst(usbEndOfBurst),
        .busy         (busy),
        .underrunCount(underrunCount),
        .debugState   (debugState)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Emulated FIFO contents and input drive values
    logic [9:0]  fifo_q[$];
    bit          rst_v, en_v, ready_v, tm_v, hold_empty_v;

    // Reference model: burst progress counted in words, gap in remaining busy cycles
    bit          m_active;
    int          m_sent, m_gap, m_test, m_under;
    logic [15:0] m_data;
    bit          m_write, m_eob;

    // Observation of the current burst
    logic [15:0] obs_q[$];
    logic [15:0] tm_q[$];
    int          n_write, n_eob, post_eob_busy;
    bit          eob_seen;

    task automatic fill(input int n, input bit ramp);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(ramp ? 10'(i) : 10'($urandom_range(0, 1023)));
        end
    endtask

    task automatic step();
        logic       exp_ack;
        logic [9:0] head;
        reset        = rst_v;
        enable       = en_v;
        usbReady     = ready_v;
        testMode     = tm_v;
        fifoEmpty    = hold_empty_v || (fifo_q.size() == 0);
        fifoHalfFull = (fifo_q.size() >= BW / 2);
        head         = (fifo_q.size() > 0) ? fifo_q[0] : 10'($urandom_range(0, 1023));
        fifoData     = head;
        #1;
        exp_ack = !rst_v && m_active && ready_v && !fifoEmpty;
        check_eq("fifo_ack", fifoAck, exp_ack);
        if (fifoAck && fifo_q.size() > 0) void'(fifo_q.pop_front());

        m_write = 1'b0;
        m_eob   = 1'b0;
        if (rst_v) begin
            m_active = 1'b0; m_gap = 0; m_sent = 0; m_test = 0; m_under = 0; m_data = 16'd0;
        end else if (m_active) begin
            if (ready_v && !fifoEmpty) begin
                m_write = 1'b1;
                m_data  = tm_v ? 16'(m_test) : {6'd0, head};
                if (tm_v) m_test = (m_test + 1) % 1024;
                m_sent++;
                if (m_sent == BW) begin
                    m_eob    = 1'b1;
                    m_active = 1'b0;
                    m_gap    = GAP + 1;
                end
            end else if (ready_v && m_under < 65535) begin
                m_under++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (en_v && fifoHalfFull && ready_v) begin
            m_active = 1'b1;
            m_sent   = 0;
        end

        @(posedge clock);
        #1;
        check_eq("usb_write", usbWrite, m_write);
        check_eq("usb_eob", usbEndOfBurst, m_eob);
        check_eq("usb_data", usbData, m_data);
        check_eq("busy", busy, (m_active || m_gap > 0));
        check_eq("underrun_count", underrunCount, m_under);
        if (usbWrite) begin
            obs_q.push_back(usbData);
            n_write++;
        end
        if (usbEndOfBurst) begin
            n_eob++;
            eob_seen = 1'b1;
        end else if (eob_seen && busy && !usbWrite) begin
            post_eob_busy++;
        end
    endtask

    // stall_kind: 1 = usbReady low, 2 = FIFO shown empty; -1 disables an event
    task automatic do_burst(input int stall_at, input int stall_kind, input int drop_at,
                            input int reset_at, input bit tm);
        int stall_left = 3;
        bit started    = 1'b0;
        bit finished   = 1'b0;
        obs_q.delete();
        n_write = 0; n_eob = 0; post_eob_busy = 0; eob_seen = 1'b0;
        en_v = 1'b1;
        tm_v = tm;
        for (int cyc = 0; cyc < 200; cyc++) begin
            ready_v      = 1'b1;
            hold_empty_v = 1'b0;
            rst_v        = 1'b0;
            if (started && m_active) begin
                if (m_sent == stall_at && stall_left > 0) begin
                    if (stall_kind == 1) ready_v = 1'b0;
                    else hold_empty_v = 1'b1;
                    stall_left--;
                end
                if (m_sent == drop_at) en_v = 1'b0;
                if (m_sent == reset_at) rst_v = 1'b1;
            end
            step();
            if (m_active) started = 1'b1;
            if (started && !m_active && m_gap == 0) begin
                finished = 1'b1;
                break;
            end
        end
        check_eq("burst_complete", finished, 1'b1);
        rst_v = 1'b0;
    endtask

    task automatic check_ramp(input string tag);
        check_eq({tag, "_count"}, n_write, BW);
        for (int i = 0; i < obs_q.size(); i++) begin
            check_eq({tag, "_word"}, obs_q[i], i);
        end
        check_eq({tag, "_eob"}, n_eob, 1);
    endtask

    initial begin
        m_active = 1'b0; m_sent = 0; m_gap = 0; m_test = 0; m_under = 0; m_data = 16'd0;
        hold_empty_v = 1'b0; tm_v = 1'b0;

        // Reset held with a full FIFO and a ready link
        fill(BW, 1'b1);
        rst_v = 1'b1; en_v = 1'b1; ready_v = 1'b1;
        repeat (3) step();
        check_eq("reset_data", usbData, 16'd0);
        check_eq("reset_busy", busy, 1'b0);
        rst_v = 1'b0;

        // Clean burst
        do_burst(-1, 0, -1, -1, 1'b0);
        check_ramp("t2");
        check_eq("t2_gap_cycles", post_eob_busy, GAP);
        check_eq("t2_idle", busy, 1'b0);

        // Link back-pressure after word 5
        fill(BW, 1'b1);
        do_burst(5, 1, -1, -1, 1'b0);
        check_ramp("t3");
        check_eq("t3_underrun", underrunCount, 16'd0);

        // FIFO empty for 3 cycles after word 8
        fill(BW, 1'b1);
        do_burst(8, 2, -1, -1, 1'b0);
        check_ramp("t4");
        check_eq("t4_underrun", underrunCount, 16'd3);

        // Enable dropped mid-burst: burst completes, no new one starts
        fill(BW, 1'b1);
        do_burst(-1, 0, 4, -1, 1'b0);
        check_ramp("t6a");
        fill(BW, 1'b1);
        repeat (5) step();
        check_eq("t6a_stay_idle", busy, 1'b0);

        // Reset mid-burst at word 4
        do_burst(-1, 0, -1, 4, 1'b0);
        check_eq("t6b_write", usbWrite, 1'b0);
        check_eq("t6b_busy", busy, 1'b0);
        check_eq("t6b_no_eob", n_eob, 0);
        check_eq("t6b_words", n_write, 4);
        fifo_q.delete();

        // Test pattern across counter wrap (counter cleared by the reset above)
        tm_q.delete();
        for (int b = 0; b < 65; b++) begin
            fill(BW, 1'b0);
            do_burst(-1, 0, -1, -1, 1'b1);
            foreach (obs_q[i]) tm_q.push_back(obs_q[i]);
        end
        check_eq("t5_count", tm_q.size(), 65 * BW);
        if (tm_q.size() >= 1025) begin
            check_eq("t5_word_1022", tm_q[1022], 16'h03FE);
            check_eq("t5_word_1023", tm_q[1023], 16'h03FF);
            check_eq("t5_word_1024", tm_q[1024], 16'h0000);
        end

        // Randomized traffic
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rst_v        = ($urandom_range(0, 199) == 0);
            en_v         = ($urandom_range(0, 3) != 0);
            ready_v      = ($urandom_range(0, 4) != 0);
            hold_empty_v = ($urandom_range(0, 9) == 0);
            tm_v         = ($urandom_range(0, 1) == 1);
            if (fifo_q.size() < 20 && $urandom_range(0, 2) != 0) fill(2, 1'b0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
